inst_pair_serializer: RTL and testbench
=======================================

Name: inst_pair_serializer

Overview:
- Reverse-direction counterpart of the front-end pair-gathering buffer.
- Accepts SUPERSCALAR-wide bundles of instruction_info_reg_t (with per-slot valid mask) and emits them one instruction per cycle, in program order, over a valid/ready handshake.
- Sits between a 2-wide producer (decode/rename group) and a single-issue consumer (e.g. ROB/commit port or scalar dispatch); buffers up to DEPTH bundles to absorb consumer stalls.

Parameters:
- DEPTH, 4, number of bundle entries in the internal queue (power of two)
- DEPTH_BITS, 2, log2(DEPTH)
- SUPERSCALAR, 2, instructions per input bundle
- SUPERSCALAR_BITS, 1, log2(SUPERSCALAR)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-low (rst==0 resets on clk edge)
- flush  input  1  discard all buffered instructions
- in_valid  input  1  bundle offered
- in_inst  input  instruction_info_reg_t[SUPERSCALAR]  bundle, slot 0 oldest
- in_mask  input  SUPERSCALAR  per-slot valid bits
- in_ready  output  1  queue can accept a bundle this cycle
- out_valid  output  1  out_inst holds a valid instruction
- out_inst  output  instruction_info_reg_t  oldest pending instruction; '0 when out_valid==0
- out_ready  input  1  consumer accepts out_inst this cycle

Behaviour:
- State: bundle storage [DEPTH], mask storage [DEPTH], head/tail pointers DEPTH_BITS+1 wide (MSB is wrap bit), slot index SUPERSCALAR_BITS wide, remaining-mask for head entry.
- Empty: head==tail. Full: low bits equal, wrap bits differ.
- in_ready = !full (combinational, not dependent on out_ready; no same-cycle pass-through when full).
- Enqueue when in_valid && in_ready && in_mask!=0: write bundle+mask at tail, tail+1. in_valid with in_mask==0: accepted (handshake completes), nothing written.
- Output combinational from head entry: out_valid = !empty; out_inst = slot of lowest set bit of head's remaining mask; else '0.
- Dequeue on out_valid && out_ready: clear that bit in remaining mask; if no bits remain, head+1 and next entry's mask loaded as remaining mask. Masked-off slots never appear on out_inst and cost no cycles.
- Latency: bundle accepted at edge N appears on out_inst after edge N (visible cycle N+1) if queue was empty. Full bundle drains in 2 cycles with out_ready held high.
- Simultaneous enqueue and dequeue: both take effect; count unchanged when head entry finishes in the same cycle.
- Pointer wrap: natural modulo 2^(DEPTH_BITS+1); order preserved across wrap.
- flush (when rst==1): next edge head=tail=0, slot/remaining mask cleared; simultaneous enqueue ignored; out_valid=0 next cycle. in_ready stays 1 during flush cycle.
- Reset (rst==0): pointers 0, all storage and masks '0; outputs: out_valid=0, out_inst='0, in_ready=1. Reset mid-drain discards partial bundle. Reset has priority over flush and enqueue.
- X-safety: out_inst driven '0 whenever out_valid==0.

Decomposition:
- rv32i_types package: instruction_info_reg_t (existing); add inst_bundle_t (instruction_info_reg_t[SUPERSCALAR] plus SUPERSCALAR-bit mask) for reuse by the pair buffer and downstream.
- One natural sub-module: bundle_fifo (DEPTH×inst_bundle_t circular queue with full/empty, push/pop); serializer slot logic stays in the top.

Test Plan:
- Reset then single bundle {A,B}, mask 2'b11, out_ready=1 -> out A in cycle 1, B in cycle 2, out_valid=0 cycle 3; in_ready=1 throughout.
- Partial bundle mask 2'b10 ({X,C}) -> only C emitted, 1 cycle; mask 2'b00 with in_valid=1 -> accepted, no output.
- out_ready=0, push 4 bundles -> in_ready=0 after 4th; 5th bundle held off; release out_ready -> 8 instructions in order; in_ready re-asserts the cycle after head entry fully drains.
- Continuous push every other cycle with out_ready=1 for 20 bundles -> pointers wrap several times, output order matches input, no gaps/duplicates.
- Flush while head bundle half-drained (A emitted, B pending) with in_valid=1 -> B and new bundle never appear; out_valid=0 next cycle; following bundle {D,E} emits D, E.
- Drive rst=0 for one edge mid-drain -> out_valid=0, out_inst='0, in_ready=1 next cycle; rst=1 with in_valid=0 -> stays empty.

Source files
------------

// File: rtl/inst_pair_serializer_pkg.sv
// Shared types for the instruction pair serializer: instruction record, bundle
// record and the slot-selection helper used to walk a bundle in program order.
package inst_pair_serializer_pkg;

  localparam int DEPTH            = 4;
  localparam int DEPTH_BITS       = 2;
  localparam int SUPERSCALAR      = 2;
  localparam int SUPERSCALAR_BITS = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } instruction_info_reg_t;

  typedef struct packed {
    instruction_info_reg_t [SUPERSCALAR-1:0] inst;
    logic [SUPERSCALAR-1:0]                  mask;
  } inst_bundle_t;

  // Index of the lowest set bit (the oldest slot still pending); 0 when none set.
  function automatic logic [SUPERSCALAR_BITS-1:0] lowest_set(input logic [SUPERSCALAR-1:0] m);
    logic [SUPERSCALAR_BITS-1:0] idx;
    idx = '0;
    for (int i = SUPERSCALAR - 1; i >= 0; i--) begin
      if (m[i]) idx = i[SUPERSCALAR_BITS-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/inst_pair_serializer_if.sv
// Producer-side bundle handshake and consumer-side single-instruction handshake.
interface inst_pair_serializer_if;
  import inst_pair_serializer_pkg::*;

  logic                                    in_valid;
  instruction_info_reg_t [SUPERSCALAR-1:0] in_inst;
  logic [SUPERSCALAR-1:0]                  in_mask;
  logic                                    in_ready;
  logic                                    out_valid;
  instruction_info_reg_t                   out_inst;
  logic                                    out_ready;

  modport slave (
    input  in_valid, in_inst, in_mask, out_ready,
    output in_ready, out_valid, out_inst
  );

  modport master (
    output in_valid, in_inst, in_mask, out_ready,
    input  in_ready, out_valid, out_inst
  );

endinterface

// File: rtl/inst_pair_serializer_bundle_fifo.sv
// Circular queue of DEPTH instruction bundles; pointers carry a wrap bit so
// full and empty are distinguishable without a separate counter.
module inst_pair_serializer_bundle_fifo
  import inst_pair_serializer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  inst_bundle_t data_i,
  input  logic         pop_i,
  output inst_bundle_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [DEPTH_BITS:0] head_q, head_d;
  logic [DEPTH_BITS:0] tail_q, tail_d;
  inst_bundle_t        mem_q [DEPTH];
  logic                wr_en_s;

  always_comb begin
    empty_o = (head_q == tail_q);
    full_o  = (head_q[DEPTH_BITS-1:0] == tail_q[DEPTH_BITS-1:0]) &&
              (head_q[DEPTH_BITS] != tail_q[DEPTH_BITS]);
    data_o  = mem_q[head_q[DEPTH_BITS-1:0]];
  end

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    wr_en_s = 1'b0;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push_i && !full_o) begin
        tail_d  = tail_q + {{DEPTH_BITS{1'b0}}, 1'b1};
        wr_en_s = 1'b1;
      end
      if (pop_i && !empty_o) begin
        head_d = head_q + {{DEPTH_BITS{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (wr_en_s) mem_q[tail_q[DEPTH_BITS-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/inst_pair_serializer.sv
// Serializes SUPERSCALAR-wide instruction bundles into one instruction per cycle
// in program order, buffering up to DEPTH bundles against consumer stalls.
module inst_pair_serializer
  import inst_pair_serializer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  inst_pair_serializer_if.slave  bus
);

  inst_bundle_t           in_bundle_s;
  inst_bundle_t           head_s;
  logic                   full_s, empty_s;
  logic [SUPERSCALAR-1:0] consumed_q, consumed_d;
  logic [SUPERSCALAR-1:0] rem_s, onehot_s;
  logic [SUPERSCALAR_BITS-1:0] slot_s;
  logic                   fire_s, last_s, push_s, pop_s;

  assign in_bundle_s = '{inst: bus.in_inst, mask: bus.in_mask};

  inst_pair_serializer_bundle_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push_s),
    .data_i  (in_bundle_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Remaining mask is the head entry's mask minus the slots already emitted,
  // so a newly exposed head needs no explicit load step.
  always_comb begin
    rem_s      = head_s.mask & ~consumed_q;
    slot_s     = lowest_set(rem_s);
    onehot_s   = {{(SUPERSCALAR-1){1'b0}}, 1'b1} << slot_s;
    fire_s     = !empty_s && bus.out_ready;
    last_s     = ((rem_s & ~onehot_s) == '0);
    push_s     = bus.in_valid && !full_s && (bus.in_mask != '0);
    pop_s      = fire_s && last_s;
    consumed_d = consumed_q;
    if (flush) begin
      consumed_d = '0;
    end else if (pop_s) begin
      consumed_d = '0;
    end else if (fire_s) begin
      consumed_d = consumed_q | onehot_s;
    end else begin
      consumed_d = consumed_q;
    end
  end

  always_comb begin
    bus.in_ready  = !full_s;
    bus.out_valid = !empty_s;
    if (empty_s) begin
      bus.out_inst = '0;
    end else begin
      bus.out_inst = head_s.inst[slot_s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      consumed_q <= '0;
    end else begin
      consumed_q <= consumed_d;
    end
  end

endmodule

// File: tb/tb_inst_pair_serializer.sv
// Directed bench for inst_pair_serializer: drives after each rising edge and
// checks the combinational outputs before the next one.
module tb_inst_pair_serializer;
  import inst_pair_serializer_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   errors;
  int   checks;

  inst_pair_serializer_if bus ();

  inst_pair_serializer dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instruction_info_reg_t mk(input int n);
    instruction_info_reg_t r;
    r.pc   = 32'h0000_1000 + 32'(n) * 32'd4;
    r.inst = 32'hA000_0000 + 32'(n);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int a, input int b, input logic [1:0] m);
    bus.in_valid   = 1'b1;
    bus.in_inst[0] = mk(a);
    bus.in_inst[1] = mk(b);
    bus.in_mask    = m;
  endtask

  initial begin
    int exp_ids[$];
    int rd;
    errors = 0;
    checks = 0;
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inst = '0;
    bus.in_mask = 2'b00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_inst", bus.out_inst, 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Full bundle {A,B} drains in two cycles.
    bus.out_ready = 1'b1;
    offer(1, 2, 2'b11);
    tick();
    bus.in_valid = 1'b0;
    chk("ab_valid1", 64'(bus.out_valid), 64'd1);
    chk("ab_A", bus.out_inst, mk(1));
    chk("ab_ready1", 64'(bus.in_ready), 64'd1);
    tick();
    chk("ab_B", bus.out_inst, mk(2));
    chk("ab_ready2", 64'(bus.in_ready), 64'd1);
    tick();
    chk("ab_valid3", 64'(bus.out_valid), 64'd0);
    chk("ab_inst3", bus.out_inst, 64'd0);

    // Partial mask 2'b10 emits only slot 1; empty mask is accepted but silent.
    offer(3, 4, 2'b10);
    tick();
    bus.in_valid = 1'b0;
    chk("part_C", bus.out_inst, mk(4));
    tick();
    chk("part_done", 64'(bus.out_valid), 64'd0);
    offer(5, 6, 2'b00);
    chk("zero_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("zero_valid", 64'(bus.out_valid), 64'd0);

    // Fill the queue with the consumer stalled.
    bus.out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      offer(10 + 2 * b, 11 + 2 * b, 2'b11);
      chk("fill_ready", 64'(bus.in_ready), 64'd1);
      tick();
    end
    offer(18, 19, 2'b11);
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    chk("full_head", bus.out_inst, mk(10));
    tick();
    chk("held_ready", 64'(bus.in_ready), 64'd0);
    chk("held_head", bus.out_inst, mk(10));
    bus.out_ready = 1'b1;
    tick();
    chk("half_inst", bus.out_inst, mk(11));
    chk("half_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("reopen_ready", 64'(bus.in_ready), 64'd1);
    chk("reopen_inst", bus.out_inst, mk(12));
    tick();
    bus.in_valid = 1'b0;
    for (int k = 13; k <= 19; k++) begin
      chk("drain_valid", 64'(bus.out_valid), 64'd1);
      chk("drain_inst", bus.out_inst, mk(k));
      tick();
    end
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Push every other cycle for 20 bundles; pointers wrap several times.
    rd = 0;
    for (int c = 0; c < 48; c++) begin
      if ((c % 2 == 0) && (c < 40)) begin
        offer(100 + c, 101 + c, 2'b11);
        exp_ids.push_back(100 + c);
        exp_ids.push_back(101 + c);
        chk("wrap_in_ready", 64'(bus.in_ready), 64'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        if (rd < exp_ids.size()) begin
          chk("wrap_inst", bus.out_inst, mk(exp_ids[rd]));
        end else begin
          chk("wrap_extra", 64'(bus.out_valid), 64'd0);
        end
        rd++;
      end
      tick();
    end
    chk("wrap_count", 64'(rd), 64'd40);
    chk("wrap_empty", 64'(bus.out_valid), 64'd0);

    // Flush with the head bundle half drained and a new bundle offered.
    offer(200, 201, 2'b11);
    tick();
    bus.in_valid = 1'b0;
    chk("fl_A", bus.out_inst, mk(200));
    tick();
    chk("fl_B_pending", bus.out_inst, mk(201));
    flush = 1'b1;
    offer(202, 203, 2'b11);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_inst", bus.out_inst, 64'd0);
    tick();
    chk("fl_still_empty", 64'(bus.out_valid), 64'd0);
    offer(210, 211, 2'b11);
    tick();
    bus.in_valid = 1'b0;
    chk("fl_D", bus.out_inst, mk(210));
    tick();
    chk("fl_E", bus.out_inst, mk(211));
    tick();
    chk("fl_done", 64'(bus.out_valid), 64'd0);

    // Reset mid-drain discards the partial bundle and everything queued.
    offer(220, 221, 2'b11);
    tick();
    offer(222, 223, 2'b11);
    chk("rs_A", bus.out_inst, mk(220));
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("rs_B_pending", bus.out_inst, mk(221));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rs_valid", 64'(bus.out_valid), 64'd0);
    chk("rs_inst", bus.out_inst, 64'd0);
    chk("rs_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("rs_stays_empty", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    offer(230, 231, 2'b11);
    tick();
    bus.in_valid = 1'b0;
    chk("rs_post_first", bus.out_inst, mk(230));
    tick();
    chk("rs_post_second", bus.out_inst, mk(231));
    tick();
    chk("rs_post_empty", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
